mem_port_arbiter: RTL

//  Shares one unified memory port between the IF stage (instruction read) and the MEM stage (data read/write).

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D), fixed D priority.
// Optional IF anti-starvation promotion is compiled in with `define ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        DBG_STATE     // 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE
);

  // Handshake: a requester holds READ/WRITE (and its address/data) high until its
  // BUSYWAIT falls; BUSYWAIT is low for exactly the DONE cycle of its own transaction.
  // Toward memory, strobes stay high from ISSUE until the WAIT cycle where
  // MEM_BUSYWAIT is low; that cycle's MEM_READDATA is the read result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_req;
  logic              i_promoted;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CNT_W-1:0] starve_q, starve_d;
  assign i_promoted = I_READ && (starve_q == CNT_W'(STARVE_LIMIT));
`else
  assign i_promoted = 1'b0;
`endif

  assign d_req = D_READ | D_WRITE;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_FAIRNESS_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_promoted || (!d_req && I_READ)) begin
          owner_d     = OWN_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = I_ADDRESS;
          state_d     = S_ISSUE;
`ifdef ARB_FAIRNESS_EN
          starve_d    = '0;
`endif
        end else if (d_req) begin
          // Both strobes high counts as a store.
          owner_d     = OWN_D;
          mem_read_d  = ~D_WRITE;
          mem_write_d = D_WRITE;
          mem_addr_d  = D_ADDRESS;
          mem_wdata_d = D_WRITEDATA;
          state_d     = S_ISSUE;
`ifdef ARB_FAIRNESS_EN
          if (I_READ && (starve_q != '1)) starve_d = starve_q + 1'b1;
`endif
        end
      end
      // Memory only raises MEM_BUSYWAIT a cycle after the strobe, so it is not looked at here.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          if (mem_read_q) begin
            if (owner_q == OWN_I) i_rdata_d = MEM_READDATA;
            else                  d_rdata_d = MEM_READDATA;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_FAIRNESS_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_FAIRNESS_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign I_BUSYWAIT    = I_READ & ~((state_q == S_DONE) && (owner_q == OWN_I));
  assign D_BUSYWAIT    = d_req  & ~((state_q == S_DONE) && (owner_q == OWN_D));
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign DBG_STATE     = state_q;

endmodule
